// File: rtl/mul_seq_if.sv
// Handshake/operand bundle for the sequential shift-add multiplier.
interface mul_seq_if #(
  parameter int width = 6
);
  logic                   start;
  logic                   sign;
  logic [width-1:0]       multiplicand;
  logic [width-1:0]       multiplier;
  logic [2*width-1:0]     product;
  logic                   ready;
  logic                   done;

  modport master (output start, sign, multiplicand, multiplier,
                  input  product, ready, done);
  modport slave  (input  start, sign, multiplicand, multiplier,
                  output product, ready, done);
endinterface

// File: rtl/mul_seq.sv
// Sequential signed/unsigned multiplier: one shift-add step per cycle on
// operand magnitudes, sign applied once when the result is registered.
module mul_seq #(
  parameter int width = 6
) (
  input  logic        clk,
  input  logic        rst,
  mul_seq_if.slave    bus
);
  localparam int CW = $clog2(width + 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;

  logic [width-1:0]   a_mag, b_mag, a_in_mag, b_in_mag;
  logic [2*width:0]   acc, acc_step;
  logic [CW-1:0]      cnt;
  logic               neg, done_r, accept, last;
  logic [2*width-1:0] product_r, result;

  // Magnitudes are width-bit unsigned, so -2^(width-1) maps to 2^(width-1).
  always_comb begin
    a_in_mag = (bus.sign && bus.multiplicand[width-1]) ? -bus.multiplicand : bus.multiplicand;
    b_in_mag = (bus.sign && bus.multiplier[width-1])   ? -bus.multiplier   : bus.multiplier;
  end

  always_comb begin
    acc_step = (acc + (b_mag[0] ? {1'b0, a_mag, {width{1'b0}}} : '0)) >> 1;
    result   = neg ? -acc_step[2*width-1:0] : acc_step[2*width-1:0];
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN: if (cnt == CW'(1)) begin
        last       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_mag     <= '0;
      b_mag     <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      product_r <= '0;
      done_r    <= 1'b0;
    end else begin
      state  <= state_next;
      done_r <= last;
      if (accept) begin
        a_mag <= a_in_mag;
        b_mag <= b_in_mag;
        neg   <= bus.sign & (bus.multiplicand[width-1] ^ bus.multiplier[width-1]);
        acc   <= '0;
        cnt   <= CW'(width);
      end else if (state == RUN) begin
        acc   <= acc_step;
        b_mag <= b_mag >> 1;
        cnt   <= cnt - CW'(1);
        if (last) product_r <= result;
      end
    end
  end

  assign bus.product = product_r;
  assign bus.ready   = (state == IDLE);
  assign bus.done    = done_r;
endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 The block SHALL have parameter `width`, default 6, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port `start`, input, 1 bit: request a multiply; sampled only while `ready`=1.
REQ-005 The block SHALL have port `sign`, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with `start`.
REQ-006 The block SHALL have port `multiplicand`, input, `width` bits: operand A, sampled with `start`.
REQ-007 The block SHALL have port `multiplier`, input, `width` bits: operand B, sampled with `start`.
REQ-008 The block SHALL have port `product`, output, 2*`width` bits: registered result A*B.
REQ-009 The block SHALL have port `ready`, output, 1 bit: block idle and able to accept `start`.
REQ-010 The block SHALL have port `done`, output, 1 bit: one-cycle pulse marking that `product` has just been updated.

Function
REQ-011 The block SHALL implement states IDLE and RUN, with `ready`=1 exactly when in IDLE.
REQ-012 In IDLE with `start`=1 at edge k, the block SHALL latch operands and `sign`, load the bit counter with `width`, clear the accumulator, and enter RUN.
REQ-013 In IDLE with `start`=0, the block SHALL hold all state, and `product` SHALL keep its last value.
REQ-014 The block SHALL ignore `start` while in RUN, with no effect on the operation in progress.
REQ-015 In signed mode, the block SHALL convert each operand to its magnitude at the edge that accepts `start`, and SHALL record negate = A[msb] XOR B[msb]; in unsigned mode negate SHALL be 0.
REQ-016 Magnitudes SHALL be held in `width` bits unsigned, so that the most-negative operand (-2^(width-1)) maps to magnitude 2^(width-1) without overflow.
REQ-017 Each RUN cycle SHALL perform one shift-add step: if the current low multiplier-magnitude bit is 1, add the multiplicand magnitude into the upper half of a 2*`width`+1-bit accumulator; then shift the accumulator right 1, shift the multiplier magnitude right 1, and decrement the counter.
REQ-018 RUN SHALL last exactly `width` cycles, with the final step at edge k+`width`.
REQ-019 At edge k+`width`, the block SHALL load `product` with the accumulated magnitude, two's-complement negated if negate=1 (modulo 2^(2*`width`)), return to IDLE, and drive `done`=1 for that one cycle.
REQ-020 A zero result SHALL never be negated to a nonzero value: -0 = 0.
REQ-021 While in RUN, `product` SHALL hold the previous result; intermediate accumulator values SHALL never be visible on `product`.
REQ-022 `start`=1 in the same cycle as `done`=1 SHALL be accepted, giving back-to-back operations with a throughput of one result per `width`+1 cycles.
REQ-023 Operand inputs SHALL be allowed to change freely after acceptance without affecting the result.
REQ-024 The product width SHALL be exact: the unsigned maximum (2^w-1)^2 and the signed extreme (-2^(w-1))^2 both fit in 2*`width` bits with no truncation.

Reset
REQ-025 `rst`=1 at any edge SHALL force IDLE, with `ready`=1, `done`=0, `product`=0, and the counter, accumulator and negate flag cleared.
REQ-026 `rst` asserted mid-RUN SHALL abort the operation with no `done` pulse and no `product` update.
REQ-027 `rst` SHALL take priority over `start`; a `start` coincident with `rst` SHALL be dropped.
REQ-028 On the first cycle after `rst` deasserts, the block SHALL accept `start`.

Verification (width=6)
REQ-029 Unsigned max: `sign`=0, A=63, B=63, `start` at edge k -> `ready`=0 for cycles k..k+5, `done`=1 after edge k+6, `product`=0xF81 (3969).
REQ-030 Signed extremes: `sign`=1, A=-32 (0x20), B=-32 -> `product`=0x400 (1024); and A=-32, B=31 -> `product`=0xC20 (-992).
REQ-031 Signed sign/zero: A=-1 (0x3F), B=5 -> `product`=0xFFB (-5); and A=0, B=-7 -> `product`=0x000 with `done` pulsing once.
REQ-032 Busy/back-to-back: `start` re-asserted with new operands during RUN -> ignored, and the first result is unchanged; `start` held high through `done` -> the second operation is accepted on the `done` cycle and its `done` follows 7 cycles later.
REQ-033 Reset mid-op: `rst` pulsed 3 cycles into RUN -> the next cycle shows `ready`=1 and `product`=0, no `done` pulse; a following 7*9 multiply yields 63.
